// File: rtl/hash_bank_port_ctrl.sv
// Front end for one single-port hash/history SRAM bank: buffered inserts, lookups with
// write-buffer forwarding, and an in-order valid/ready response queue.
module hash_bank_port_ctrl #(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int WBUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 rd_valid,
  output logic                 rd_ready,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_fwd,
  output logic                 sram_write_enable,
  output logic                 sram_read_enable,
  output logic [ADDR_SIZE-1:0] sram_address,
  output logic [WORD_SIZE-1:0] sram_write_data,
  input  logic [WORD_SIZE-1:0] sram_read_data
);

  localparam int WP_W = $clog2(WBUF_DEPTH);
  localparam int WC_W = $clog2(WBUF_DEPTH + 1);
  localparam logic [WC_W-1:0] WBUF_FULL_CNT = WC_W'(WBUF_DEPTH);

  // Response queue holds three entries so that a read in flight plus two queued results
  // never block a one-per-cycle lookup stream.
  function automatic logic [1:0] rq_next(input logic [1:0] ptr);
    logic [1:0] nxt;
    if (ptr == 2'd2) begin
      nxt = 2'd0;
    end else begin
      nxt = ptr + 2'd1;
    end
    return nxt;
  endfunction

  logic [ADDR_SIZE-1:0] wb_addr_r [WBUF_DEPTH];
  logic [WORD_SIZE-1:0] wb_data_r [WBUF_DEPTH];
  logic [WP_W-1:0]      wb_wptr_r;
  logic [WP_W-1:0]      wb_rptr_r;
  logic [WC_W-1:0]      wb_count_r;

  logic                 inflight_r;
  logic                 fwd_hit_r;
  logic [WORD_SIZE-1:0] fwd_data_r;

  logic [WORD_SIZE-1:0] rq_data_r [3];
  logic                 rq_fwd_r  [3];
  logic [1:0]           rq_wptr_r;
  logic [1:0]           rq_rptr_r;
  logic [1:0]           rq_count_r;

  logic                 wb_full_s;
  logic                 wb_empty_s;
  logic [2:0]           rq_occ_s;
  logic                 wr_fire_s;
  logic                 rd_fire_s;
  logic                 drain_s;
  logic                 rq_valid_s;
  logic                 rq_push_s;
  logic                 rq_pop_s;
  logic [WORD_SIZE-1:0] rq_push_data_s;
  logic                 fwd_hit_s;
  logic [WORD_SIZE-1:0] fwd_data_s;
  logic [WP_W-1:0]      fwd_idx_s;

  assign wb_full_s  = (wb_count_r == WBUF_FULL_CNT);
  assign wb_empty_s = (wb_count_r == {WC_W{1'b0}});
  assign rq_occ_s   = {1'b0, rq_count_r} + {2'b00, inflight_r};

  assign wr_ready  = rst_n && !wb_full_s;
  assign rd_ready  = rst_n && !wb_full_s && (rq_occ_s < 3'd3);
  assign wr_fire_s = wr_valid && wr_ready;
  assign rd_fire_s = rd_valid && rd_ready;

  // A full buffer takes the port outright; otherwise reads win and writes use idle cycles.
  assign drain_s = rst_n && (wb_full_s || (!rd_fire_s && !wb_empty_s));

  assign sram_write_enable = drain_s;
  assign sram_read_enable  = rd_fire_s;

  assign rq_valid_s     = rst_n && (rq_count_r != 2'd0);
  assign rq_pop_s       = rq_valid_s && resp_ready;
  assign rq_push_s      = inflight_r;
  assign rq_push_data_s = fwd_hit_r ? fwd_data_r : sram_read_data;

  assign resp_valid = rq_valid_s;

  // SRAM port address/data mux
  always_comb begin
    sram_address    = {ADDR_SIZE{1'b0}};
    sram_write_data = {WORD_SIZE{1'b0}};
    if (drain_s) begin
      sram_address    = wb_addr_r[wb_rptr_r];
      sram_write_data = wb_data_r[wb_rptr_r];
    end else if (rd_fire_s) begin
      sram_address    = rd_addr;
      sram_write_data = {WORD_SIZE{1'b0}};
    end else begin
      sram_address    = {ADDR_SIZE{1'b0}};
      sram_write_data = {WORD_SIZE{1'b0}};
    end
  end

  // Response head presented only while valid
  always_comb begin
    resp_data = {WORD_SIZE{1'b0}};
    resp_fwd  = 1'b0;
    if (rq_valid_s) begin
      resp_data = rq_data_r[rq_rptr_r];
      resp_fwd  = rq_fwd_r[rq_rptr_r];
    end else begin
      resp_data = {WORD_SIZE{1'b0}};
      resp_fwd  = 1'b0;
    end
  end

  // Walk the buffer oldest to newest so the last match is the newest pending write
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {WORD_SIZE{1'b0}};
    fwd_idx_s  = wb_rptr_r;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      fwd_idx_s = wb_rptr_r + WP_W'(i);
      if ((WC_W'(i) < wb_count_r) && (wb_addr_r[fwd_idx_s] == rd_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = wb_data_r[fwd_idx_s];
      end else begin
        fwd_hit_s  = fwd_hit_s;
        fwd_data_s = fwd_data_s;
      end
    end
  end

  // Payload storage; validity is tracked by the counters, so no reset is needed here
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      wb_addr_r[wb_wptr_r] <= wr_addr;
      wb_data_r[wb_wptr_r] <= wr_data;
    end
    if (rq_push_s) begin
      rq_data_r[rq_wptr_r] <= rq_push_data_s;
      rq_fwd_r[rq_wptr_r]  <= fwd_hit_r;
    end
  end

  // Queue pointers, occupancy and the in-flight lookup stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_wptr_r  <= {WP_W{1'b0}};
      wb_rptr_r  <= {WP_W{1'b0}};
      wb_count_r <= {WC_W{1'b0}};
      inflight_r <= 1'b0;
      fwd_hit_r  <= 1'b0;
      fwd_data_r <= {WORD_SIZE{1'b0}};
      rq_wptr_r  <= 2'd0;
      rq_rptr_r  <= 2'd0;
      rq_count_r <= 2'd0;
    end else begin
      if (wr_fire_s) begin
        wb_wptr_r <= wb_wptr_r + WP_W'(1);
      end
      if (drain_s) begin
        wb_rptr_r <= wb_rptr_r + WP_W'(1);
      end
      case ({wr_fire_s, drain_s})
        2'b10:   wb_count_r <= wb_count_r + WC_W'(1);
        2'b01:   wb_count_r <= wb_count_r - WC_W'(1);
        default: wb_count_r <= wb_count_r;
      endcase

      inflight_r <= rd_fire_s;
      if (rd_fire_s) begin
        fwd_hit_r  <= fwd_hit_s;
        fwd_data_r <= fwd_data_s;
      end

      if (rq_push_s) begin
        rq_wptr_r <= rq_next(rq_wptr_r);
      end
      if (rq_pop_s) begin
        rq_rptr_r <= rq_next(rq_rptr_r);
      end
      case ({rq_push_s, rq_pop_s})
        2'b10:   rq_count_r <= rq_count_r + 2'd1;
        2'b01:   rq_count_r <= rq_count_r - 2'd1;
        default: rq_count_r <= rq_count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_bank_port_ctrl.sv
// Directed bench for hash_bank_port_ctrl with a behavioural single-port SRAM attached.
module tb_hash_bank_port_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [3:0] wr_addr = 4'h0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_valid = 1'b0;
  logic       rd_ready;
  logic [3:0] rd_addr = 4'h0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_data;
  logic       resp_fwd;
  logic       sram_write_enable;
  logic       sram_read_enable;
  logic [3:0] sram_address;
  logic [7:0] sram_write_data;
  logic [7:0] sram_read_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [16];
  logic       wrote_addr10 = 1'b0;

  always #5 clk = ~clk;

  hash_bank_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_fwd(resp_fwd),
    .sram_write_enable(sram_write_enable), .sram_read_enable(sram_read_enable),
    .sram_address(sram_address), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  // sram1p model: write on edge, read data registered for the following cycle
  always @(posedge clk) begin
    if (sram_write_enable) begin
      mem[sram_address] <= sram_write_data;
      if (sram_address == 4'd10) wrote_addr10 <= 1'b1;
    end
    if (sram_read_enable) sram_read_data <= mem[sram_address];
  end

  typedef struct {
    logic       rst_n; logic wv; logic [3:0] wa; logic [7:0] wd;
    logic       rv; logic [3:0] ra; logic rr;
    logic       e_wrr; logic e_rdr; logic e_we; logic e_re;
    logic [3:0] e_addr; logic [7:0] e_wdata;
    logic       e_rv; logic [7:0] e_rdata; logic e_fwd;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic wv, input logic [3:0] wa, input logic [7:0] wd,
                       input logic rv, input logic [3:0] ra, input logic rr);
    @(negedge clk);
    rst_n = r; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr = ra; resp_ready = rr;
    #1;
  endtask

  logic [7:0] exp_a [8];
  logic [7:0] exp_b [3];

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    sram_read_data = 8'h00;

    //            rst  wv  wa    wd     rv  ra    rr  | wrr rdr we  re  addr  wdat   rv  rdata  fwd
    vecs[0]  = '{1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[1]  = '{1'b0,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b0,1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[2]  = '{1'b1,1'b1,4'h3,8'hA5,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[3]  = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b1,1'b0,4'h3,8'hA5,1'b0,8'h00,1'b0};
    vecs[4]  = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[5]  = '{1'b1,1'b0,4'h0,8'h00,1'b1,4'h3,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h3,8'h00,1'b0,8'h00,1'b0};
    vecs[6]  = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[7]  = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,8'hA5,1'b0};
    vecs[8]  = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[9]  = '{1'b1,1'b1,4'h5,8'h11,1'b1,4'h5,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h5,8'h00,1'b0,8'h00,1'b0};
    vecs[10] = '{1'b1,1'b1,4'h5,8'h22,1'b1,4'h5,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h5,8'h00,1'b0,8'h00,1'b0};
    vecs[11] = '{1'b1,1'b0,4'h0,8'h00,1'b1,4'h5,1'b1, 1'b0,1'b0,1'b1,1'b0,4'h5,8'h11,1'b1,8'h00,1'b0};
    vecs[12] = '{1'b1,1'b0,4'h0,8'h00,1'b1,4'h5,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h5,8'h00,1'b1,8'h11,1'b1};
    vecs[13] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b1,1'b0,4'h5,8'h22,1'b0,8'h00,1'b0};
    vecs[14] = '{1'b1,1'b0,4'h0,8'h00,1'b1,4'h5,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h5,8'h00,1'b1,8'h22,1'b1};
    vecs[15] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[16] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,8'h22,1'b0};
    vecs[17] = '{1'b1,1'b1,4'h7,8'h33,1'b1,4'h7,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h7,8'h00,1'b0,8'h00,1'b0};
    vecs[18] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b1,1'b0,4'h7,8'h33,1'b0,8'h00,1'b0};
    vecs[19] = '{1'b1,1'b0,4'h0,8'h00,1'b1,4'h7,1'b1, 1'b1,1'b1,1'b0,1'b1,4'h7,8'h00,1'b1,8'h00,1'b0};
    vecs[20] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};
    vecs[21] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b1,8'h33,1'b0};
    vecs[22] = '{1'b1,1'b0,4'h0,8'h00,1'b0,4'h0,1'b1, 1'b1,1'b1,1'b0,1'b0,4'h0,8'h00,1'b0,8'h00,1'b0};

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rst_n, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].ra, vecs[i].rr);
      chk($sformatf("row%0d wr_ready", i), 32'(wr_ready), 32'(vecs[i].e_wrr));
      chk($sformatf("row%0d rd_ready", i), 32'(rd_ready), 32'(vecs[i].e_rdr));
      chk($sformatf("row%0d sram_we", i), 32'(sram_write_enable), 32'(vecs[i].e_we));
      chk($sformatf("row%0d sram_re", i), 32'(sram_read_enable), 32'(vecs[i].e_re));
      chk($sformatf("row%0d resp_valid", i), 32'(resp_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_we || vecs[i].e_re || !vecs[i].rst_n)
        chk($sformatf("row%0d sram_addr", i), 32'(sram_address), 32'(vecs[i].e_addr));
      if (vecs[i].e_we || !vecs[i].rst_n)
        chk($sformatf("row%0d sram_wdata", i), 32'(sram_write_data), 32'(vecs[i].e_wdata));
      if (vecs[i].e_rv || !vecs[i].rst_n) begin
        chk($sformatf("row%0d resp_data", i), 32'(resp_data), 32'(vecs[i].e_rdata));
        chk($sformatf("row%0d resp_fwd", i), 32'(resp_fwd), 32'(vecs[i].e_fwd));
      end
    end

    // Back-to-back lookups 0..7, responses on consecutive cycles from T+2
    exp_a[0] = 8'h00; exp_a[1] = 8'h00; exp_a[2] = 8'h00; exp_a[3] = 8'hA5;
    exp_a[4] = 8'h00; exp_a[5] = 8'h22; exp_a[6] = 8'h00; exp_a[7] = 8'h33;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, 4'h0, 8'h00, (k < 8), 4'(k), 1'b1);
      if (k < 8) chk($sformatf("stream%0d rd_ready", k), 32'(rd_ready), 32'd1);
      chk($sformatf("stream%0d resp_valid", k), 32'(resp_valid), 32'((k >= 2) && (k < 10)));
      if ((k >= 2) && (k < 10)) chk($sformatf("stream%0d resp_data", k), 32'(resp_data), 32'(exp_a[k-2]));
    end

    // Back-pressure: exactly three lookups accepted, results held, then delivered in order
    exp_b[0] = 8'hA5; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, (c == 0) ? 4'h3 : (c == 1) ? 4'h5 : (c == 2) ? 4'h7 : 4'h0, 1'b0);
      chk($sformatf("bp%0d rd_ready", c), 32'(rd_ready), 32'(c < 3));
      if (c >= 2) begin
        chk($sformatf("bp%0d resp_valid", c), 32'(resp_valid), 32'd1);
        chk($sformatf("bp%0d resp_data_hold", c), 32'(resp_data), 32'hA5);
      end
    end
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1);
      chk($sformatf("drain%0d resp_valid", c), 32'(resp_valid), 32'(c < 3));
      if (c < 3) chk($sformatf("drain%0d resp_data", c), 32'(resp_data), 32'(exp_b[c]));
    end

    // Fill the write buffer under a continuous read stream, then reset mid-stream
    drive(1'b1, 1'b1, 4'd9, 8'h44, 1'b1, 4'h0, 1'b1);
    chk("fill0 sram_re", 32'(sram_read_enable), 32'd1);
    chk("fill0 sram_we", 32'(sram_write_enable), 32'd0);
    drive(1'b1, 1'b1, 4'd10, 8'h55, 1'b1, 4'h0, 1'b1);
    chk("fill1 sram_re", 32'(sram_read_enable), 32'd1);
    chk("fill1 wr_ready", 32'(wr_ready), 32'd1);
    drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b1);
    chk("full sram_we", 32'(sram_write_enable), 32'd1);
    chk("full sram_re", 32'(sram_read_enable), 32'd0);
    chk("full rd_ready", 32'(rd_ready), 32'd0);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    chk("full sram_addr", 32'(sram_address), 32'd9);
    chk("full sram_wdata", 32'(sram_write_data), 32'h44);
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b1);
      chk($sformatf("resume%0d sram_re", c), 32'(sram_read_enable), 32'd1);
      chk($sformatf("resume%0d sram_we", c), 32'(sram_write_enable), 32'd0);
    end
    drive(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'h1, 1'b1);
    chk("rst wr_ready", 32'(wr_ready), 32'd0);
    chk("rst rd_ready", 32'(rd_ready), 32'd0);
    chk("rst sram_we", 32'(sram_write_enable), 32'd0);
    chk("rst sram_re", 32'(sram_read_enable), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst sram_addr", 32'(sram_address), 32'd0);
    chk("rst resp_data", 32'(resp_data), 32'd0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1);
      chk($sformatf("post_rst%0d sram_we", c), 32'(sram_write_enable), 32'd0);
      chk($sformatf("post_rst%0d resp_valid", c), 32'(resp_valid), 32'd0);
      chk($sformatf("post_rst%0d wr_ready", c), 32'(wr_ready), 32'd1);
    end
    chk("discarded write never reached sram", 32'(wrote_addr10), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
